pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use, redirect, memory-busy and halt-drain control.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES   = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_memRead,
  input  logic [2:0]  idex_writereg,
  input  logic        exmem_memRead,
  input  logic [2:0]  exmem_writereg,
  input  logic [2:0]  ifid_rs,
  input  logic [2:0]  ifid_rt,
  input  logic        ifid_rsValid,
  input  logic        ifid_rtValid,
  input  logic        ex_redirect,
  input  logic        id_halt,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_flush,
  output logic        halted,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] mem_stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic        stalled
);

  typedef enum logic [2:0] {
    RUN,
    LUSTALL,
    MEMWAIT,
    DRAIN,
    HALTED
  } state_e;

  localparam bit         LU_MULTI = (LU_BUBBLES > 1);
  localparam logic [1:0] LU_LOAD  = 2'(LU_BUBBLES - 1);
  localparam logic [2:0] DRN_LAST = 3'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  state_e     eff;
  logic [1:0] bub_q, bub_d;
  logic [2:0] drn_q, drn_d;

  logic hit_ex, hit_mem, lu_hit;

  assign hit_ex = idex_memRead &
    ((ifid_rsValid & (ifid_rs == idex_writereg)) |
     (ifid_rtValid & (ifid_rt == idex_writereg)));

  assign hit_mem = exmem_memRead &
    ((ifid_rsValid & (ifid_rs == exmem_writereg)) |
     (ifid_rtValid & (ifid_rt == exmem_writereg)));

  assign lu_hit = hit_ex | (LU_MULTI & hit_mem);

  // While frozen, behave as the state that was interrupted
  assign eff = (state_q == MEMWAIT) ? ret_q : state_q;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    stalled     = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    bub_d       = bub_q;
    drn_d       = drn_q;
    if (state_q == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      halted   = 1'b1;
    end else if (dmem_busy) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      stalled     = 1'b1;
      state_d     = MEMWAIT;
      ret_d       = eff;
    end else begin
      state_d = eff;
      unique case (eff)
        RUN, LUSTALL: begin
          if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
            bub_d      = '0;
          end else if (eff == LUSTALL) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stalled    = 1'b1;
            bub_d      = bub_q - 2'd1;
            if (bub_q == 2'd1) state_d = RUN;
          end else if (lu_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stalled    = 1'b1;
            if (LU_MULTI) begin
              bub_d   = LU_LOAD;
              state_d = LUSTALL;
            end
          end else if (imem_busy) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stalled    = 1'b1;
          end else if (id_halt) begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end
        DRAIN: begin
          // An older branch resolving here means the halt was wrong-path
          if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
            drn_d      = '0;
          end else begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            drn_d      = drn_q + 3'd1;
            if (drn_q == DRN_LAST) begin
              state_d = HALTED;
              drn_d   = '0;
            end
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bub_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bub_q   <= bub_d;
      drn_q   <= drn_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic        lu_src;
  logic        ev_lu, ev_mem, ev_fl;
  logic [15:0] lu_q, mem_q, fl_q;

  // Load-use and imem stalls drive identical strobes; split by cause
  assign lu_src = lu_hit | (eff == LUSTALL);
  assign ev_lu  = stalled & idex_flush & lu_src;
  assign ev_mem = memwb_flush |
                  (stalled & idex_flush & ~lu_src);
  assign ev_fl  = ifid_flush & idex_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q  <= '0;
      mem_q <= '0;
      fl_q  <= '0;
    end else begin
      if (ev_lu && lu_q != 16'hFFFF)
        lu_q <= lu_q + 16'd1;
      if (ev_mem && mem_q != 16'hFFFF)
        mem_q <= mem_q + 16'd1;
      if (ev_fl && fl_q != 16'hFFFF)
        fl_q <= fl_q + 16'd1;
    end
  end

  assign lu_stall_cnt  = lu_q;
  assign mem_stall_cnt = mem_q;
  assign flush_cnt     = fl_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: LU_BUBBLES=1 and =2 instances
// driven in parallel, checked against an event-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int DRAIN = 4;

  typedef struct {
    bit       rst;
    bit       idex_memRead;
    bit [2:0] idex_writereg;
    bit       exmem_memRead;
    bit [2:0] exmem_writereg;
    bit [2:0] ifid_rs;
    bit [2:0] ifid_rt;
    bit       rsV;
    bit       rtV;
    bit       redir;
    bit       halt;
    bit       imem;
    bit       dmem;
  } stim_t;

  typedef struct {
    bit halted;
    int bub;
    bit drain;
    int dleft;
    int nlu;
    int nmem;
    int nfl;
  } mdl_t;

  typedef struct {
    logic [8:0]  o1;
    logic [8:0]  o2;
    logic [47:0] p1;
    logic [47:0] p2;
    string       nm;
    bit          chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_memRead, exmem_memRead;
  logic [2:0] idex_writereg, exmem_writereg;
  logic [2:0] ifid_rs, ifid_rt;
  logic       ifid_rsValid, ifid_rtValid;
  logic       ex_redirect, id_halt, imem_busy, dmem_busy;
  wire  [8:0] oa, ob;
  wire  [47:0] pa, pb;

  mdl_t m1, m2;
  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_BUBBLES(1), .DRAIN_CYCLES(DRAIN)) dut1 (
    .clk(clk), .rst(rst),
    .idex_memRead(idex_memRead), .idex_writereg(idex_writereg),
    .exmem_memRead(exmem_memRead), .exmem_writereg(exmem_writereg),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_rsValid(ifid_rsValid), .ifid_rtValid(ifid_rtValid),
    .ex_redirect(ex_redirect), .id_halt(id_halt),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_en(oa[8]), .ifid_en(oa[7]), .ifid_flush(oa[6]),
    .idex_en(oa[5]), .idex_flush(oa[4]), .exmem_en(oa[3]),
    .memwb_flush(oa[2]), .halted(oa[1]),
`ifdef PIPE_HAZARD_PERF_EN
    .lu_stall_cnt(pa[47:32]), .mem_stall_cnt(pa[31:16]),
    .flush_cnt(pa[15:0]),
`endif
    .stalled(oa[0])
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(2), .DRAIN_CYCLES(DRAIN)) dut2 (
    .clk(clk), .rst(rst),
    .idex_memRead(idex_memRead), .idex_writereg(idex_writereg),
    .exmem_memRead(exmem_memRead), .exmem_writereg(exmem_writereg),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_rsValid(ifid_rsValid), .ifid_rtValid(ifid_rtValid),
    .ex_redirect(ex_redirect), .id_halt(id_halt),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_en(ob[8]), .ifid_en(ob[7]), .ifid_flush(ob[6]),
    .idex_en(ob[5]), .idex_flush(ob[4]), .exmem_en(ob[3]),
    .memwb_flush(ob[2]), .halted(ob[1]),
`ifdef PIPE_HAZARD_PERF_EN
    .lu_stall_cnt(pb[47:32]), .mem_stall_cnt(pb[31:16]),
    .flush_cnt(pb[15:0]),
`endif
    .stalled(ob[0])
  );

`ifndef PIPE_HAZARD_PERF_EN
  assign pa = '0;
  assign pb = '0;
`endif

  function automatic bit reads(bit ld, bit [2:0] wr, stim_t s);
    return ld && ((s.rsV && s.ifid_rs == wr) ||
                  (s.rtV && s.ifid_rt == wr));
  endfunction

  function automatic logic [15:0] sat(int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // Outputs packed as {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,memwb_fl,halted,stalled}
  function automatic logic [8:0] mstep(inout mdl_t m, input stim_t s,
                                       input int lub);
    bit pc = 1, ie = 1, ifl = 0, de = 1, dfl = 0;
    bit xe = 1, wfl = 0, hl = 0, st = 0;
    bit hit;
    hit = reads(s.idex_memRead, s.idex_writereg, s) ||
          (lub > 1 && reads(s.exmem_memRead, s.exmem_writereg, s));
    if (m.halted) begin
      pc = 0; ie = 0; de = 0; xe = 0; hl = 1;
    end else if (s.dmem) begin
      pc = 0; ie = 0; de = 0; xe = 0; wfl = 1; st = 1;
      m.nmem++;
    end else if (s.redir) begin
      ifl = 1; dfl = 1;
      m.bub = 0; m.drain = 0;
      m.nfl++;
    end else if (m.drain) begin
      pc = 0; ifl = 1;
      m.dleft--;
      if (m.dleft == 0) begin
        m.drain = 0; m.halted = 1;
      end
    end else if (m.bub > 0 || hit) begin
      pc = 0; ie = 0; dfl = 1; st = 1;
      m.bub = (m.bub > 0) ? m.bub - 1 : lub - 1;
      m.nlu++;
    end else if (s.imem) begin
      pc = 0; ie = 0; dfl = 1; st = 1;
      m.nmem++;
    end else if (s.halt) begin
      m.drain = 1; m.dleft = DRAIN;
    end
    if (s.rst) m = '{default: 0};
    return {pc, ie, ifl, de, dfl, xe, wfl, hl, st};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst            = ($urandom_range(99) < 2);
    s.idex_memRead   = ($urandom_range(99) < 50);
    s.idex_writereg  = 3'($urandom_range(7));
    s.exmem_memRead  = ($urandom_range(99) < 50);
    s.exmem_writereg = 3'($urandom_range(7));
    s.ifid_rs        = 3'($urandom_range(7));
    s.ifid_rt        = 3'($urandom_range(7));
    s.rsV            = ($urandom_range(99) < 70);
    s.rtV            = ($urandom_range(99) < 50);
    s.redir          = ($urandom_range(99) < 15);
    s.halt           = ($urandom_range(99) < 4);
    s.imem           = ($urandom_range(99) < 20);
    s.dmem           = ($urandom_range(99) < 15);
    return s;
  endfunction

  task automatic drive(input stim_t s, input string nm, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = s.rst;
    idex_memRead   = s.idex_memRead;
    idex_writereg  = s.idex_writereg;
    exmem_memRead  = s.exmem_memRead;
    exmem_writereg = s.exmem_writereg;
    ifid_rs        = s.ifid_rs;
    ifid_rt        = s.ifid_rt;
    ifid_rsValid   = s.rsV;
    ifid_rtValid   = s.rtV;
    ex_redirect    = s.redir;
    id_halt        = s.halt;
    imem_busy      = s.imem;
    dmem_busy      = s.dmem;
`ifdef PIPE_HAZARD_PERF_EN
    e.p1 = {sat(m1.nlu), sat(m1.nmem), sat(m1.nfl)};
    e.p2 = {sat(m2.nlu), sat(m2.nmem), sat(m2.nfl)};
`else
    e.p1 = '0;
    e.p2 = '0;
`endif
    e.o1  = mstep(m1, s, 1);
    e.o2  = mstep(m2, s, 2);
    e.nm  = nm;
    e.chk = chk;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          n_chk++;
          if (oa === e.o1 && pa === e.p1) n_pass++;
          else $display("FAIL %s lub1: got %b/%h want %b/%h",
                        e.nm, oa, pa, e.o1, e.p1);
          n_chk++;
          if (ob === e.o2 && pb === e.p2) n_pass++;
          else $display("FAIL %s lub2: got %b/%h want %b/%h",
                        e.nm, ob, pb, e.o2, e.p2);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s, h;
    m1 = '{default: 0};
    m2 = '{default: 0};
    s = idle();
    s.rst = 1;
    drive(s, "rst_first", 0);
    drive(s, "rst_hold", 1);
    drive(idle(), "reset_state", 1);

    h = idle();
    h.idex_memRead = 1; h.idex_writereg = 3;
    h.ifid_rs = 3; h.rsV = 1;
    drive(h, "lu_rs", 1);
    drive(idle(), "lu_after1", 1);
    drive(idle(), "lu_after2", 1);

    drive(h, "lu2_first", 1);
    s = idle(); s.redir = 1;
    drive(s, "lu2_redirect", 1);
    drive(idle(), "lu2_run", 1);

    s = idle();
    s.exmem_memRead = 1; s.exmem_writereg = 5;
    s.ifid_rt = 5; s.rtV = 1;
    drive(s, "lu_exmem", 1);
    drive(idle(), "lu_exmem2", 1);
    drive(idle(), "lu_exmem3", 1);

    s = h; s.dmem = 1; s.redir = 1;
    for (int i = 0; i < 3; i++) drive(s, "dmem_freeze", 1);
    s = idle(); s.redir = 1;
    drive(s, "dmem_release", 1);
    drive(idle(), "dmem_after", 1);

    s = idle(); s.imem = 1; s.redir = 1;
    drive(s, "imem_redirect", 1);
    s = idle(); s.imem = 1;
    drive(s, "imem_only", 1);

    s = idle(); s.halt = 1;
    drive(s, "halt_pulse", 1);
    for (int i = 0; i < DRAIN; i++) drive(idle(), "drain", 1);
    for (int i = 0; i < 6; i++) begin
      s = rnd(); s.rst = 0;
      drive(s, "halted_sticky", 1);
    end
    s = idle(); s.rst = 1;
    drive(s, "halt_rst", 1);
    drive(idle(), "post_halt_run", 1);

    s = idle(); s.halt = 1;
    drive(s, "halt_wrongpath", 1);
    drive(idle(), "wp_drain", 1);
    s = idle(); s.redir = 1;
    drive(s, "wp_redirect", 1);
    for (int i = 0; i < 6; i++) drive(idle(), "wp_run", 1);

    s = idle(); s.halt = 1;
    drive(s, "halt_mid", 1);
    drive(idle(), "mid_drain", 1);
    s = idle(); s.rst = 1;
    drive(s, "mid_rst", 1);
    drive(idle(), "mid_run", 1);

    for (int i = 0; i < 4000; i++) drive(rnd(), "random", 1);

    stim_done = 1;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
